// File: rtl/pc_ctrl_pkg.sv
// Shared encodings, FSM state type and boot-address default for the fetch-side PC sequencer.
package pc_ctrl_pkg;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  localparam logic [31:0] BOOT_ADDRESS_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StRedirect
  } state_e;

endpackage

// File: rtl/pc_ctrl_if.sv
// Fetch-control bundle between hazard/CSR logic, PC mux and the PC sequencer.
interface pc_ctrl_if;

  logic        ahb_ready_in;
  logic        stall_in;
  logic        branch_taken_in;
  logic        misaligned_instr_in;
  logic        trap_req_in;
  logic        mret_in;
  logic [31:0] pc_mux_in;
  logic [1:0]  pc_src_out;
  logic [31:0] pc_out;
  logic        instr_req_out;
  logic        flush_out;
  logic        misaligned_trap_out;

  // Surrounding fetch logic.
  modport master (
    output ahb_ready_in, stall_in, branch_taken_in, misaligned_instr_in,
    output trap_req_in, mret_in, pc_mux_in,
    input  pc_src_out, pc_out, instr_req_out, flush_out, misaligned_trap_out
  );

  // The sequencer itself.
  modport slave (
    input  ahb_ready_in, stall_in, branch_taken_in, misaligned_instr_in,
    input  trap_req_in, mret_in, pc_mux_in,
    output pc_src_out, pc_out, instr_req_out, flush_out, misaligned_trap_out
  );

endinterface

// File: rtl/pc_ctrl_perf.sv
// Redirect and sequential-stall event counters; both wrap at 2^32.
module pc_ctrl_perf (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        redirect_in,
  input  logic        stall_cycle_in,
  output logic [31:0] redirect_cnt_out,
  output logic [31:0] stall_cnt_out
);

  logic [31:0] redirect_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      redirect_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      if (redirect_in)    redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (stall_cycle_in) stall_cnt_q    <= stall_cnt_q + 32'd1;
    end
  end

  assign redirect_cnt_out = redirect_cnt_q;
  assign stall_cnt_out    = stall_cnt_q;

endmodule

// File: rtl/pc_ctrl.sv
// PC register owner and next-address mux select sequencer (boot > trap > mret > next).
// Define PC_CTRL_PERF_EN to add redirect/stall performance counters.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = BOOT_ADDRESS_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  pc_ctrl_if.slave    bus
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [31:0] redirect_cnt_out,
  output logic [31:0] stall_cnt_out
`endif
);

  state_e      state_q, state_d;
  logic        trap_pend_q, trap_pend_d;
  logic        mret_pend_q, mret_pend_d;
  logic [31:0] pc_q;

  logic       misaligned;
  logic       trap_any;
  logic       mret_any;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       redirect;
  logic       trap_load;
  logic       mret_load;

  assign misaligned = bus.branch_taken_in & bus.misaligned_instr_in;
  assign trap_any   = bus.trap_req_in | trap_pend_q | misaligned;
  assign mret_any   = bus.mret_in | mret_pend_q;

  always_comb begin
    pc_src = PC_SRC_NEXT;
    if (state_q == StBoot) begin
      pc_src = PC_SRC_BOOT;
    end else if (trap_any) begin
      pc_src = PC_SRC_TRAP;
    end else if (mret_any) begin
      pc_src = PC_SRC_EPC;
    end
  end

  // Redirects ignore the hazard stall; only the AHB port can hold them off.
  assign pc_en = (pc_src == PC_SRC_NEXT) ? (bus.ahb_ready_in & ~bus.stall_in) : bus.ahb_ready_in;

  assign trap_load = pc_en & (pc_src == PC_SRC_TRAP);
  assign mret_load = pc_en & (pc_src == PC_SRC_EPC);
  assign redirect  = trap_load | mret_load |
                     (pc_en & (pc_src == PC_SRC_NEXT) & bus.branch_taken_in);

  always_comb begin
    state_d     = state_q;
    trap_pend_d = trap_any & ~trap_load;
    // A trap load supersedes any outstanding return.
    mret_pend_d = mret_any & ~mret_load & ~trap_load;
    case (state_q)
      StBoot: begin
        if (bus.ahb_ready_in) state_d = StRun;
      end
      StRun, StRedirect: begin
        state_d = redirect ? StRedirect : StRun;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StBoot;
      trap_pend_q <= 1'b0;
      mret_pend_q <= 1'b0;
      pc_q        <= BOOT_ADDRESS;
    end else begin
      state_q     <= state_d;
      trap_pend_q <= trap_pend_d;
      mret_pend_q <= mret_pend_d;
      if (pc_en) pc_q <= (state_q == StBoot) ? BOOT_ADDRESS : bus.pc_mux_in;
    end
  end

  assign bus.pc_src_out          = pc_src;
  assign bus.pc_out              = pc_q;
  assign bus.instr_req_out       = ~rst_in;
  assign bus.flush_out           = (state_q == StRedirect);
  assign bus.misaligned_trap_out = misaligned;

`ifdef PC_CTRL_PERF_EN
  pc_ctrl_perf u_perf (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .redirect_in      (redirect),
    .stall_cycle_in   ((pc_src == PC_SRC_NEXT) & ~pc_en),
    .redirect_cnt_out (redirect_cnt_out),
    .stall_cnt_out    (stall_cnt_out)
  );
`endif

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-side sequencer that owns the architectural program-counter register and drives the select of the PC next-address mux. It decides each cycle whether the PC takes the boot address, the trap vector, the saved EPC or the sequential/branch target. It holds the PC while the AHB instruction port or the pipeline stalls, and latches trap/return requests that arrive while the PC cannot update. It flushes IF/ID after every redirect and sits between the hazard/CSR logic and the PC mux in the fetch stage.

## Interface
- BOOT_ADDRESS, 32'h0000_0000, PC value loaded on reset and in BOOT
- clk_in  input  1  rising-edge clock
- rst_in  input  1  synchronous, active-high reset
- ahb_ready_in  input  1  instruction AHB port ready; PC may update only when 1
- stall_in  input  1  hazard-unit stall; blocks sequential/branch update only
- branch_taken_in  input  1  taken branch/jump resolved this cycle
- misaligned_instr_in  input  1  PC mux reports misaligned branch target
- trap_req_in  input  1  exception/interrupt request pulse from CSR unit
- mret_in  input  1  MRET retiring pulse
- pc_mux_in  input  32  next-PC value from PC mux
- pc_src_out  output  2  mux select: 00 boot, 01 EPC, 10 trap vector, 11 next_pc
- pc_out  output  32  registered PC
- instr_req_out  output  1  fetch request valid
- flush_out  output  1  kill IF/ID contents
- misaligned_trap_out  output  1  misaligned-fetch exception to CSR unit

## Operation
- States: BOOT, RUN, REDIRECT. Reset enters BOOT; BOOT -> RUN on the first cycle with ahb_ready_in=1.
- Pending flags trap_pend and mret_pend are set when their event occurs and the PC cannot load. Each is cleared when its load happens.
- Misaligned event = branch_taken_in & misaligned_instr_in. It is treated as a trap request: it sets trap_pend if unconsumed, and misaligned_trap_out=1 for that cycle.
- pc_src_out is combinational:
  - 00 in BOOT;
  - else 10 if trap_req_in | trap_pend | misaligned event;
  - else 01 if mret_in | mret_pend;
  - else 11.
- Priority is boot > trap > mret > branch/sequential.
- Load enable pc_en:
  - ahb_ready_in & ~stall_in when pc_src_out=11;
  - ahb_ready_in alone when pc_src_out is 00, 01 or 10. Redirects override stall.
- On pc_en the PC register takes pc_mux_in. In BOOT it takes BOOT_ADDRESS.
- A redirect is a load with pc_src_out 01 or 10, or 11 with branch_taken_in=1. A redirect moves the state to REDIRECT for exactly one cycle, with flush_out=1; then RUN.
- Events arriving in REDIRECT are evaluated normally. A second redirect keeps the state in REDIRECT.
- Simultaneous trap and mret: the trap loads and mret_pend is set. mret_pend is then dropped on that trap load, because the trap supersedes the return.
- A branch coinciding with a pending trap is discarded; the trap wins.

## Timing
- Reset values: pc_out=BOOT_ADDRESS, pc_src_out=00, instr_req_out=0, flush_out=0, misaligned_trap_out=0, state BOOT, both pending flags 0.
- Reset mid-operation clears all pending events in the same edge.
- instr_req_out=1 in RUN and REDIRECT, and in BOOT only after reset is deasserted.
- PC load latency: 1 cycle. pc_out reflects pc_mux_in on the edge where pc_en=1.
- flush_out is high the cycle after a redirect load, for 1 cycle per redirect.
- A pending event is consumed on the first edge with ahb_ready_in=1. There is no extra latency beyond ready.
- A PC increment of 0xFFFF_FFFC + 4 wraps to 0; no special handling.

## Configuration
- PC_CTRL_PERF_EN defined:
  - adds redirect_cnt_out [31:0], counting redirects;
  - adds stall_cnt_out [31:0], counting cycles with pc_src_out=11 and pc_en=0;
  - both are reset to 0 by rst_in and wrap at 2^32.
- PC_CTRL_PERF_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package holds:
  - pc_src encodings: PC_SRC_BOOT=2'b00, PC_SRC_EPC=2'b01, PC_SRC_TRAP=2'b10, PC_SRC_NEXT=2'b11;
  - the state enum;
  - the BOOT_ADDRESS default.
- Single module. The optional counters go in sub-module pc_ctrl_perf, instantiated under PC_CTRL_PERF_EN.

## Test plan
- Reset held 3 cycles, then released with ahb_ready_in=1 -> pc_out=0, pc_src_out=00 for one cycle, then 11. pc_out=4 on the next edge.
- RUN at pc=0x100, stall_in=1 for 2 cycles -> pc_out holds 0x100. A trap_req_in during the stall loads pc_mux_in=0x80 immediately and flush_out=1 the next cycle.
- trap_req_in pulse while ahb_ready_in=0 for 3 cycles -> trap_pend holds and pc_src_out=10 throughout. The PC loads the vector on the first ready cycle.
- trap_req_in and mret_in in the same cycle -> pc_src_out=10, the trap vector loads and no EPC load follows.
- branch_taken_in with misaligned_instr_in, target 0x102 -> misaligned_trap_out=1 and pc_src_out=10. The trap vector loads and 0x102 is never loaded.
- With PC_CTRL_PERF_EN: 2 redirects and 5 stall cycles -> redirect_cnt_out=2, stall_cnt_out=5. Reset returns both to 0.
